// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants, op codes and FSM state type for the ALU arbiter
// Purpose: ALU op-code constants, default widths and arbiter state enum.
// Ports: none (package).
package alu_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_OP_W   = 4;

    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_SLL  = 4'd3;
    localparam logic [3:0] ALU_SRL  = 4'd4;
    localparam logic [3:0] ALU_AND  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - bundle of requester, response and external ALU signals
// Purpose: groups the two requester channels, the shared response and the ALU drive/return.
// Ports: none; modport slave is the arbiter side, master is the requester/ALU side.
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W
);
    logic [1:0]             rq_valid;
    logic [1:0]             rq_ready;
    logic [1:0][OP_W-1:0]   rq_op;
    logic [1:0][DATA_W-1:0] rq_a;
    logic [1:0][DATA_W-1:0] rq_b;
    logic [1:0][4:0]        rq_shamt;
    logic [1:0]             rs_valid;
    logic [1:0]             rs_ready;
    logic [DATA_W-1:0]      rs_result;
    logic                   rs_zero;
    logic [OP_W-1:0]        alu_ctrl;
    logic [DATA_W-1:0]      alu_a;
    logic [DATA_W-1:0]      alu_b;
    logic [4:0]             alu_shamt;
    logic [DATA_W-1:0]      alu_result;
    logic                   alu_zero;

    modport slave (
        input  rq_valid, rq_op, rq_a, rq_b, rq_shamt, rs_ready, alu_result, alu_zero,
        output rq_ready, rs_valid, rs_result, rs_zero, alu_ctrl, alu_a, alu_b, alu_shamt
    );

    modport master (
        output rq_valid, rq_op, rq_a, rq_b, rq_shamt, rs_ready, alu_result, alu_zero,
        input  rq_ready, rs_valid, rs_result, rs_zero, alu_ctrl, alu_a, alu_b, alu_shamt
    );
endinterface

// File: rtl/alu_arb_grant.sv
// rtl/alu_arb_grant.sv - combinational two-way grant
// Purpose: picks one of two requesters. With ALU_ARB_RR_EN defined a tie goes to the
//          requester not served last; otherwise requester 0 always wins a tie.
// Ports: valid_i request vector, last_i (ALU_ARB_RR_EN only) 1 = requester 1 served last,
//        gnt_o one-hot grant (zero when nothing requests).
module alu_arb_grant (
    input  logic [1:0] valid_i,
`ifdef ALU_ARB_RR_EN
    input  logic       last_i,
`endif
    output logic [1:0] gnt_o
);
    always_comb begin
        gnt_o = valid_i;
        if (valid_i == 2'b11) begin
`ifdef ALU_ARB_RR_EN
            gnt_o = last_i ? 2'b01 : 2'b10;
`else
            gnt_o = 2'b01;
`endif
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of an external combinational ALU
// Purpose: grants one operation at a time, drives the ALU for one cycle, holds the result
//          for the owning requester until it is consumed. Macro ALU_ARB_RR_EN selects
//          round-robin instead of fixed priority.
// Ports: clk, reset (async, active high), bus (alu_arbiter_if.slave).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W
) (
    input  logic          clk,
    input  logic          reset,
    alu_arbiter_if.slave  bus
);
    arb_state_e        state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [4:0]        sh_q, sh_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              zero_q, zero_d;
    logic [1:0]        gnt;
    logic [1:0]        req_live;
`ifdef ALU_ARB_RR_EN
    logic              last_q, last_d;
`endif

    // Requests are masked while reset is high so no grant escapes during reset.
    assign req_live = bus.rq_valid & {2{~reset}};

    alu_arb_grant u_grant (
        .valid_i (req_live),
`ifdef ALU_ARB_RR_EN
        .last_i  (last_q),
`endif
        .gnt_o   (gnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            owner_q <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
`ifdef ALU_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            owner_q <= owner_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
`ifdef ALU_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        sh_d          = sh_q;
        owner_d       = owner_q;
        res_d         = res_q;
        zero_d        = zero_q;
`ifdef ALU_ARB_RR_EN
        last_d        = last_q;
`endif
        bus.rq_ready  = 2'b00;
        bus.rs_valid  = 2'b00;
        bus.rs_result = '0;
        bus.rs_zero   = 1'b0;
        bus.alu_ctrl  = '0;
        bus.alu_a     = '0;
        bus.alu_b     = '0;
        bus.alu_shamt = '0;

        case (state_q)
            IDLE: begin
                if (gnt != 2'b00) begin
                    bus.rq_ready = gnt;
                    owner_d      = gnt[1];
                    op_d         = bus.rq_op[gnt[1]];
                    a_d          = bus.rq_a[gnt[1]];
                    b_d          = bus.rq_b[gnt[1]];
                    sh_d         = bus.rq_shamt[gnt[1]];
`ifdef ALU_ARB_RR_EN
                    last_d       = gnt[1];
`endif
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                bus.alu_ctrl  = op_q;
                bus.alu_a     = a_q;
                bus.alu_b     = b_q;
                bus.alu_shamt = sh_q;
                res_d         = bus.alu_result;
                zero_d        = bus.alu_zero;
                state_d       = RESP;
            end
            RESP: begin
                bus.rs_valid[owner_q] = 1'b1;
                bus.rs_result         = res_q;
                bus.rs_zero           = zero_q;
                // Only the owner's ready completes the transfer.
                if (bus.rs_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter
module tb_alu_arbiter;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
    } exp_t;

    logic clk;
    logic reset;
    alu_arbiter_if bus ();

    alu_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    exp_t q0[$];
    exp_t q1[$];

    logic        busy = 1'b0;
    logic        m_last = 1'b1;
    logic        m_owner = 1'b0;
    logic [3:0]  m_op = 4'd0;
    logic [31:0] m_a = 32'd0;
    logic [31:0] m_b = 32'd0;
    logic [4:0]  m_sh = 5'd0;
    int          exec_at = -1;
    int          resp_at = -1;

    logic [1:0]  rs_force = 2'b00;
    logic [1:0]  rs_fval = 2'b00;

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return b << sh;
            ALU_SRL:  return b >> sh;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_NOR:  return ~(a | b);
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default:  return 32'd0;
        endcase
    endfunction

    // External ALU
    assign bus.alu_result = ref_alu(bus.alu_ctrl, bus.alu_a, bus.alu_b, bus.alu_shamt);
    assign bus.alu_zero   = (bus.alu_result == 32'd0);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input bit ok, input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Response-side ready: random unless forced by the directed phases.
    initial begin
        bus.rs_ready = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++)
                bus.rs_ready[k] = rs_force[k] ? rs_fval[k] : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input int i, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input int wd);
        bit   got;
        int   lim;
        exp_t e;
        got = 1'b0;
        lim = (wd > 0) ? wd : 200;
        @(posedge clk);
        #1;
        bus.rq_op[i]    = op;
        bus.rq_a[i]     = a;
        bus.rq_b[i]     = b;
        bus.rq_shamt[i] = sh;
        bus.rq_valid[i] = 1'b1;
        for (int n = 0; n < lim && !got; n++) begin
            @(negedge clk);
            if (bus.rq_ready[i]) got = 1'b1;
        end
        @(posedge clk);
        if (got) begin
            e.res  = ref_alu(op, a, b, sh);
            e.zero = (e.res == 32'd0);
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
        end else if (wd == 0) begin
            chk(1'b0, "accept_timeout", 96'(i), 96'(lim));
        end
        #1;
        bus.rq_valid[i] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(n < 400, "drain_timeout", 96'(q0.size() + q1.size()), 96'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic rand_stream(input int i, input int n);
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [4:0]  sh;
        for (int k = 0; k < n; k++) begin
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            sh = 5'($urandom);
            send(i, op, a, b, sh, ($urandom_range(0, 4) == 0) ? 2 : 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    // Monitor: arbitration model, latency, ALU drive, response scoreboard.
    initial begin
        logic [1:0]  exp_g;
        logic [1:0]  own_v;
        logic [1:0]  prev_v;
        logic [31:0] prev_res;
        logic        prev_zero;
        logic        g;
        exp_t        e;
        int          t;
        t = 0;
        prev_v = 2'b00;
        prev_res = 32'd0;
        prev_zero = 1'b0;
        forever begin
            @(negedge clk);
            t++;
            if (reset) begin
                chk({bus.rq_ready, bus.rs_valid, bus.alu_ctrl, bus.alu_shamt, |bus.rs_result,
                     bus.rs_zero, |bus.alu_a, |bus.alu_b} == '0, "reset_outputs",
                    96'({bus.rq_ready, bus.rs_valid, bus.alu_ctrl, bus.alu_shamt}), 96'd0);
                q0.delete();
                q1.delete();
                busy = 1'b0;
                m_last = 1'b1;
                exec_at = -1;
                resp_at = -1;
                prev_v = 2'b00;
            end else begin
                if (!busy && bus.rq_valid != 2'b00) begin
                    if (bus.rq_valid == 2'b11) begin
`ifdef ALU_ARB_RR_EN
                        exp_g = m_last ? 2'b01 : 2'b10;
`else
                        exp_g = 2'b01;
`endif
                    end else begin
                        exp_g = bus.rq_valid;
                    end
                    chk(bus.rq_ready == exp_g, "grant", 96'(bus.rq_ready), 96'(exp_g));
                end else begin
                    chk(bus.rq_ready == 2'b00, "ready_quiet", 96'(bus.rq_ready), 96'd0);
                end

                if (t == exec_at) begin
                    chk({bus.alu_ctrl, bus.alu_a, bus.alu_b, bus.alu_shamt} == {m_op, m_a, m_b, m_sh},
                        "alu_drive", 96'({bus.alu_ctrl, bus.alu_a, bus.alu_b, bus.alu_shamt}),
                        96'({m_op, m_a, m_b, m_sh}));
                    chk(bus.rs_valid == 2'b00, "exec_no_resp", 96'(bus.rs_valid), 96'd0);
                end else begin
                    chk({bus.alu_ctrl, bus.alu_a, bus.alu_b, bus.alu_shamt} == '0, "alu_idle",
                        96'({bus.alu_ctrl, bus.alu_a, bus.alu_b, bus.alu_shamt}), 96'd0);
                end

                own_v = m_owner ? 2'b10 : 2'b01;
                if (t == resp_at)
                    chk(bus.rs_valid == own_v, "latency", 96'(bus.rs_valid), 96'(own_v));

                if (bus.rs_valid != 2'b00) begin
                    chk(busy && bus.rs_valid == own_v, "rs_owner", 96'({busy, bus.rs_valid}),
                        96'({1'b1, own_v}));
                    if (prev_v != 2'b00)
                        chk({bus.rs_result, bus.rs_zero} == {prev_res, prev_zero}, "payload_stable",
                            96'({bus.rs_result, bus.rs_zero}), 96'({prev_res, prev_zero}));
                    prev_v = bus.rs_valid;
                    prev_res = bus.rs_result;
                    prev_zero = bus.rs_zero;
                    if ((bus.rs_valid & bus.rs_ready) != 2'b00) begin
                        if (bus.rs_valid[1] ? (q1.size() == 0) : (q0.size() == 0)) begin
                            chk(1'b0, "unexpected_resp", 96'(bus.rs_result), 96'd0);
                        end else begin
                            e = bus.rs_valid[1] ? q1.pop_front() : q0.pop_front();
                            chk({bus.rs_result, bus.rs_zero} == {e.res, e.zero}, "result",
                                96'({bus.rs_result, bus.rs_zero}), 96'({e.res, e.zero}));
                        end
                        busy = 1'b0;
                        prev_v = 2'b00;
                    end
                end else begin
                    prev_v = 2'b00;
                end

                if (!busy && (bus.rq_ready & bus.rq_valid) != 2'b00) begin
                    g = bus.rq_ready[1];
                    busy = 1'b1;
                    m_owner = g;
                    m_last = g;
                    m_op = bus.rq_op[g];
                    m_a = bus.rq_a[g];
                    m_b = bus.rq_b[g];
                    m_sh = bus.rq_shamt[g];
                    exec_at = t + 1;
                    resp_at = t + 2;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.rq_valid = 2'b00;
        bus.rq_op = '0;
        bus.rq_a = '0;
        bus.rq_b = '0;
        bus.rq_shamt = '0;
        rs_force = 2'b11;
        rs_fval = 2'b11;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Single ADD with immediate consume
        send(0, ALU_ADD, 32'd5, 32'd7, 5'd0, 0);
        drain();

        // Simultaneous requests from reset; r0 re-requests to force a second tie
        do_reset();
        fork
            begin
                send(0, ALU_SUB, 32'd3, 32'd3, 5'd0, 0);
                send(0, ALU_AND, 32'hAA, 32'h0F, 5'd0, 0);
            end
            send(1, ALU_OR, 32'hF0, 32'h0F, 5'd0, 0);
        join
        drain();

        // Held response; r1 ready pulses must not complete it
        rs_force = 2'b01;
        rs_fval = 2'b00;
        send(0, ALU_SLL, 32'd0, 32'd1, 5'd4, 0);
        repeat (7) @(negedge clk);
        chk(bus.rs_valid == 2'b01 && bus.rs_result == 32'h10, "held_resp",
            96'({bus.rs_valid, bus.rs_result}), 96'({2'b01, 32'h10}));
        rs_force = 2'b11;
        rs_fval = 2'b11;
        drain();

        // Signed vs unsigned compare, undefined op code
        send(1, ALU_SLT, 32'hFFFFFFFF, 32'd1, 5'd0, 0);
        send(1, ALU_SLTU, 32'hFFFFFFFF, 32'd1, 5'd0, 0);
        send(0, 4'd12, 32'd3, 32'd4, 5'd0, 0);
        drain();

        // Reset during EXEC abandons the operation
        send(0, ALU_ADD, 32'd1, 32'd2, 5'd0, 0);
        reset = 1'b1;
        #1;
        chk({bus.rq_ready, bus.rs_valid, bus.alu_ctrl, bus.alu_a, bus.alu_b} == '0, "reset_in_exec",
            96'({bus.rq_ready, bus.rs_valid, bus.alu_ctrl, bus.alu_a}), 96'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(posedge clk);
        send(0, ALU_SUB, 32'd10, 32'd4, 5'd0, 0);
        drain();

        // Randomised traffic with random consume and occasional withdrawal
        rs_force = 2'b00;
        fork
            rand_stream(0, 30);
            rand_stream(1, 30);
        join
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width.
REQ-002 Parameter OP_W, default 4, ALU control code width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 rq_valid[i] (i=0,1)  in  1  requester i presents an operation.
REQ-006 rq_ready[i]  out  1  operation from requester i accepted this cycle.
REQ-007 rq_op[i]  in  OP_W  ALU control code (1 ADD, 2 SUB, 3 SLL, 4 SRL, 5 AND, 6 OR, 7 NOR, 8 SLTU, 9 SLT).
REQ-008 rq_a[i], rq_b[i]  in  DATA_W  operands; rq_shamt[i]  in  5  shift amount.
REQ-009 rs_valid[i]  out  1  result for requester i available.
REQ-010 rs_ready[i]  in  1  requester i consumes result.
REQ-011 rs_result  out  DATA_W, rs_zero  out  1  shared response payload, valid with rs_valid.
REQ-012 alu_ctrl  out  OP_W; alu_a, alu_b  out  DATA_W; alu_shamt  out  5  drive to external ALU.
REQ-013 alu_result  in  DATA_W; alu_zero  in  1  combinational ALU return.

Function
REQ-014 FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-015 IDLE: if any rq_valid, grant one requester, assert its rq_ready for exactly that cycle, latch op/a/b/shamt, go EXEC; else stay IDLE.
REQ-016 rq_ready shall be 0 in EXEC and RESP; at most one rq_ready high per cycle.
REQ-017 EXEC: drive alu_* from latched registers; capture alu_result/alu_zero at cycle end; go RESP.
REQ-018 RESP: rs_valid of owner high, other low; payload stable until handshake; on rs_ready of owner go IDLE, else hold.
REQ-019 alu_ctrl shall be 0 and alu_a/alu_b/alu_shamt 0 outside EXEC.
REQ-020 Latency: accept at edge N, rs_valid high from cycle N+2; minimum issue interval 3 cycles.
REQ-021 Op codes 0 and 10-15 pass through unchanged; result/zero taken from ALU (0/1) with no error flag.
REQ-022 rs_ready of the non-owner shall be ignored.
REQ-023 rq_valid deasserted while not granted is legal; no operation recorded.

Reset
REQ-024 Asynchronous reset forces IDLE, all outputs 0, latched operands 0, grant pointer to "requester 1 last served".
REQ-025 Reset in EXEC or RESP abandons the operation; no response is ever issued for it.

Configuration
REQ-026 Macro ALU_ARB_RR_EN defined: round-robin; on simultaneous requests grant the requester not served last; pointer updates on each grant.
REQ-027 ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins simultaneous requests; pointer register absent.

Structure
REQ-028 Shared package alu_pkg holds ALU op-code constants (ALU_ADD..ALU_SLT), DATA_W default, and the FSM state enum.
REQ-029 One sub-module alu_arb_grant: combinational two-way grant from valids and pointer, macro-dependent.

Verification
REQ-030 r0 ADD a=5 b=7 accepted cycle 1 -> rs_valid[0] cycle 3, rs_result=12, rs_zero=0.
REQ-031 Both valid after reset, r0 SUB 3-3, r1 OR 0xF0|0x0F -> r0 served first (0, zero=1), then r1 0x000000FF; second simultaneous round: RR_EN grants r1 first, otherwise r0.
REQ-032 r0 SLL b=1 shamt=4 with rs_ready[0] low 5 cycles -> rs_result=0x10 held stable, rq_ready both 0 throughout, rs_ready[1] pulses ignored.
REQ-033 r1 SLT a=0xFFFFFFFF b=1 -> rs_result=1; SLTU same operands -> 0.
REQ-034 reset asserted during EXEC -> outputs 0 immediately, no rs_valid after release, next request serviced normally.
REQ-035 op 4'd12 a=3 b=4 -> rs_result=0, rs_zero=1, latency unchanged.
